// File: rtl/clk_div_gen.sv
// CHANNELS independent programmable dividers on clk, each giving a tick enable and a square wave.
// Define CLK_DIV_GEN_READBACK_EN to add rd_data, a registered readback of the selected active divisor.
module clk_div_gen #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4,
    localparam int SELW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                sync,
    input  logic                div_wr,
    input  logic [SELW-1:0]     div_sel,
    input  logic [WIDTH-1:0]    div_data,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_out,
`ifdef CLK_DIV_GEN_READBACK_EN
    output logic [WIDTH-1:0]    rd_data,
`endif
    output logic [CHANNELS-1:0] pending
);

    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef CLK_DIV_GEN_READBACK_EN
    logic [WIDTH-1:0] div_act [CHANNELS];
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [WIDTH-1:0] div_q;
        logic [WIDTH-1:0] pend_q;
        logic [WIDTH-1:0] cnt_q;
        logic             pend_flag_q;
        logic             clk_q;
        logic             tick_q;

        logic             wr_hit;
        logic             halted;
        logic             wrap;
        logic             apply;
        logic             have_new;
        logic [WIDTH-1:0] new_div;
        logic [WIDTH-1:0] cnt_next;
        logic [WIDTH-1:0] half;

        assign wr_hit   = div_wr && (div_sel == SELW'(g));
        assign halted   = (div_q == '0);
        assign wrap     = en && !halted && (cnt_q == div_q - ONE);
        assign apply    = sync || halted || wrap;
        // A write landing on an apply edge bypasses the pending register.
        assign have_new = wr_hit || pend_flag_q;
        assign new_div  = wr_hit ? div_data : pend_q;
        assign cnt_next = wrap ? '0 : cnt_q + ONE;
        assign half     = {1'b0, div_q[WIDTH-1:1]} + {{(WIDTH-1){1'b0}}, div_q[0]};

        always_ff @(posedge clk) begin
            if (reset) begin
                div_q       <= DEF;
                pend_q      <= '0;
                pend_flag_q <= 1'b0;
                cnt_q       <= '0;
                clk_q       <= 1'b0;
                tick_q      <= 1'b0;
            end else begin
                if (wr_hit) begin
                    pend_q <= div_data;
                end
                if (apply) begin
                    pend_flag_q <= 1'b0;
                    if (have_new) begin
                        div_q <= new_div;
                    end
                end else if (wr_hit) begin
                    pend_flag_q <= 1'b1;
                end

                if (sync || halted) begin
                    cnt_q  <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (en) begin
                    cnt_q  <= cnt_next;
                    tick_q <= wrap;
                    clk_q  <= (cnt_next < half);
                end
            end
        end

        assign tick[g]    = tick_q;
        assign clk_out[g] = clk_q;
        assign pending[g] = pend_flag_q;
`ifdef CLK_DIV_GEN_READBACK_EN
        assign div_act[g] = div_q;
`endif
    end

`ifdef CLK_DIV_GEN_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= DEF;
        end else begin
            rd_data <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (div_sel == SELW'(i)) begin
                    rd_data <= div_act[i];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen with two channels; expected values are hand-derived per cycle.
// Outputs are packed {ch1, ch0}.
module tb_clk_div_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        sync;
    logic        div_wr;
    logic [0:0]  div_sel;
    logic [15:0] div_data;
    logic [1:0]  tick;
    logic [1:0]  clk_out;
    logic [1:0]  pending;
`ifdef CLK_DIV_GEN_READBACK_EN
    logic [15:0] rd_data;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    clk_div_gen #(.CHANNELS(2), .WIDTH(16), .DEFAULT_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sync     (sync),
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_data (div_data),
        .tick     (tick),
        .clk_out  (clk_out),
`ifdef CLK_DIV_GEN_READBACK_EN
        .rd_data  (rd_data),
`endif
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    endtask

    task automatic check_now(input logic [1:0] c, input logic [1:0] t, input logic [1:0] p);
        chk("clk_out", clk_out, c);
        chk("tick", tick, t);
        chk("pending", pending, p);
    endtask

    task automatic cy(input logic [1:0] c, input logic [1:0] t, input logic [1:0] p);
        @(posedge clk);
        #1;
        cyc++;
        check_now(c, t, p);
    endtask

    task automatic wr(input logic [0:0] sel, input logic [15:0] data);
        div_wr   = 1'b1;
        div_sel  = sel;
        div_data = data;
    endtask

    task automatic wr_off();
        div_wr = 1'b0;
    endtask

    // Default D=4 on both channels from a fresh start: cycles 1..8.
    task automatic default_seq();
        cy(2'b11, 2'b00, 2'b00);
        cy(2'b00, 2'b00, 2'b00);
        cy(2'b00, 2'b00, 2'b00);
        cy(2'b11, 2'b11, 2'b00);
        cy(2'b11, 2'b00, 2'b00);
        cy(2'b00, 2'b00, 2'b00);
        cy(2'b00, 2'b00, 2'b00);
        cy(2'b11, 2'b11, 2'b00);
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        sync     = 1'b0;
        div_wr   = 1'b0;
        div_sel  = '0;
        div_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b1;
        cyc   = 0;
        check_now(2'b00, 2'b00, 2'b00);

        default_seq();

        // cycle 9: both cnt=1; write D=5 to channel 1
        cy(2'b11, 2'b00, 2'b00);
        wr(1'b1, 16'd5);
        cy(2'b00, 2'b00, 2'b10);
        wr_off();
        cy(2'b00, 2'b00, 2'b10);
        cy(2'b11, 2'b11, 2'b00);
        cy(2'b11, 2'b00, 2'b00);
        cy(2'b10, 2'b00, 2'b00);
        cy(2'b00, 2'b00, 2'b00);
        cy(2'b01, 2'b01, 2'b00);
        cy(2'b11, 2'b10, 2'b00);
        cy(2'b10, 2'b00, 2'b00);
        cy(2'b10, 2'b00, 2'b00);
        cy(2'b01, 2'b01, 2'b00);
        cy(2'b01, 2'b00, 2'b00);
        cy(2'b10, 2'b10, 2'b00);
        cy(2'b10, 2'b00, 2'b00);
        // cycle 24: ch0 cnt=0; write 3 then 7 to channel 0
        cy(2'b11, 2'b01, 2'b00);
        wr(1'b0, 16'd3);
        cy(2'b01, 2'b00, 2'b01);
        wr(1'b0, 16'd7);
        cy(2'b00, 2'b00, 2'b01);
        wr_off();
        cy(2'b10, 2'b10, 2'b01);
        cy(2'b11, 2'b01, 2'b00);
        cy(2'b11, 2'b00, 2'b00);
        cy(2'b01, 2'b00, 2'b00);
        cy(2'b01, 2'b00, 2'b00);
        cy(2'b10, 2'b10, 2'b00);
        cy(2'b10, 2'b00, 2'b00);
        cy(2'b10, 2'b00, 2'b00);
        // cycle 35: ch0 ticks 7 after the previous one; write D=0 to channel 0
        cy(2'b01, 2'b01, 2'b00);
        wr(1'b0, 16'd0);
        cy(2'b01, 2'b00, 2'b01);
        wr_off();
        cy(2'b11, 2'b10, 2'b01);
        cy(2'b11, 2'b00, 2'b01);
        cy(2'b10, 2'b00, 2'b01);
        cy(2'b00, 2'b00, 2'b01);
        cy(2'b00, 2'b00, 2'b01);
        cy(2'b11, 2'b11, 2'b00);
        cy(2'b10, 2'b00, 2'b00);
        // cycle 44: ch0 halted; write D=2 applies on the next edge
        cy(2'b10, 2'b00, 2'b00);
        wr(1'b0, 16'd2);
        cy(2'b00, 2'b00, 2'b00);
        wr_off();
        cy(2'b00, 2'b00, 2'b00);
        cy(2'b11, 2'b11, 2'b00);
        cy(2'b10, 2'b00, 2'b00);
        cy(2'b11, 2'b01, 2'b00);
        // cycle 50: mid-period sync
        cy(2'b00, 2'b00, 2'b00);
        sync = 1'b1;
        cy(2'b00, 2'b00, 2'b00);
        sync = 1'b0;
        cy(2'b10, 2'b00, 2'b00);
        // cycle 53: sync together with D=6 write to channel 1
        cy(2'b11, 2'b01, 2'b00);
        sync = 1'b1;
        wr(1'b1, 16'd6);
        cy(2'b00, 2'b00, 2'b00);
        sync = 1'b0;
        wr_off();
        cy(2'b10, 2'b00, 2'b00);
        cy(2'b11, 2'b01, 2'b00);
        cy(2'b00, 2'b00, 2'b00);
        cy(2'b01, 2'b01, 2'b00);
        cy(2'b00, 2'b00, 2'b00);
        // cycle 60: both tick; dropping en holds everything including tick
        cy(2'b11, 2'b11, 2'b00);
        en = 1'b0;
        cy(2'b11, 2'b11, 2'b00);
        cy(2'b11, 2'b11, 2'b00);
        en = 1'b1;
        cy(2'b10, 2'b00, 2'b00);
        // cycle 63: pending write to channel 1, then reset mid-period
        wr(1'b1, 16'd9);
        cy(2'b11, 2'b01, 2'b10);
        wr_off();
        reset = 1'b1;
        cy(2'b00, 2'b00, 2'b00);
        cy(2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        cyc = 0;
        default_seq();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
